// File: rtl/ball_motion_if.sv
// Frame-tick, serve and collision inputs plus the ball/score/lives outputs
// of the ball motion controller.
interface ball_motion_if;
    logic       FrameTick;
    logic       Serve;
    logic [2:0] ColOut;
    logic [9:0] XCord;
    logic [9:0] YCord;
    logic [9:0] Score;
    logic [1:0] Lives;
    logic [1:0] State;
    logic       MissPulse;

    modport master (
        output FrameTick, Serve, ColOut,
        input  XCord, YCord, Score, Lives, State, MissPulse
    );

    modport slave (
        input  FrameTick, Serve, ColOut,
        output XCord, YCord, Score, Lives, State, MissPulse
    );
endinterface

// File: rtl/ball_motion.sv
// Ball motion controller: direction, speed, lives and score, and the
// serve/play/miss/game-over sequence. One position step is taken per frame tick.
module ball_motion #(
    parameter int ServeX     = 320,
    parameter int ServeY     = 232,
    parameter int XMax       = 639,
    parameter int YMax       = 399,
    parameter int SpeedInit  = 2,
    parameter int SpeedMax   = 6,
    parameter int HitsPerUp  = 4,
    parameter int LivesInit  = 3,
    parameter int MissFrames = 60
) (
    input  logic          Clk,
    input  logic          Rst_n,
    ball_motion_if.slave  bus
);

    localparam int SpeedW = $clog2(SpeedMax + 1);
    localparam int HitW   = $clog2(HitsPerUp + 1);
    localparam int MissW  = $clog2(MissFrames);

    localparam logic [9:0]        ServeXC    = 10'(ServeX);
    localparam logic [9:0]        ServeYC    = 10'(ServeY);
    localparam logic [9:0]        XMaxC      = 10'(XMax);
    localparam logic [9:0]        YMaxC      = 10'(YMax);
    localparam logic [SpeedW-1:0] SpeedInitC = SpeedW'(SpeedInit);
    localparam logic [SpeedW-1:0] SpeedMaxC  = SpeedW'(SpeedMax);
    localparam logic [SpeedW-1:0] SpeedOne   = SpeedW'(1);
    localparam logic [HitW-1:0]   HitLast    = HitW'(HitsPerUp - 1);
    localparam logic [HitW-1:0]   HitOne     = HitW'(1);
    localparam logic [MissW-1:0]  MissLast   = MissW'(MissFrames - 1);
    localparam logic [MissW-1:0]  MissOne    = MissW'(1);
    localparam logic [1:0]        LivesInitC = 2'(LivesInit);
    localparam logic [9:0]        ScoreMax   = 10'h3FF;

    localparam logic [2:0] ColPaddle  = 3'b001;
    localparam logic [2:0] ColNet     = 3'b011;
    localparam logic [2:0] ColCeiling = 3'b010;
    localparam logic [2:0] ColFloor   = 3'b110;
    localparam logic [2:0] ColWall    = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        MISS = 2'b10,
        OVER = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              dirLeft_q, dirLeft_d, dirDown_q, dirDown_d;
    logic [SpeedW-1:0] speed_q, speed_d;
    logic [1:0]        lives_q, lives_d;
    logic [9:0]        score_q, score_d;
    logic              missPulse_q, missPulse_d;
    logic [2:0]        colPrev_q, colPrev_d;
    logic [HitW-1:0]   hitCnt_q, hitCnt_d;
    logic [MissW-1:0]  missCnt_q, missCnt_d;

    logic netEdge;
    logic paddleHit;

    assign netEdge   = (bus.ColOut == ColNet)    && (colPrev_q != ColNet);
    assign paddleHit = (bus.ColOut == ColPaddle) && (colPrev_q != ColPaddle);

    // Bit 10 of the 11-bit sum acts as the sign, so underflow clamps to 0.
    function automatic logic [9:0] stepAxis(input logic [9:0] pos,
                                            input logic negative,
                                            input logic [SpeedW-1:0] spd,
                                            input logic [9:0] limit);
        logic [10:0] delta;
        logic [10:0] sum;
        delta = {{(11-SpeedW){1'b0}}, spd};
        sum   = negative ? ({1'b0, pos} - delta) : ({1'b0, pos} + delta);
        if (sum[10])
            return '0;
        else if (sum[9:0] > limit)
            return limit;
        else
            return sum[9:0];
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            x_q         <= ServeXC;
            y_q         <= ServeYC;
            dirLeft_q   <= 1'b1;
            dirDown_q   <= 1'b1;
            speed_q     <= SpeedInitC;
            lives_q     <= LivesInitC;
            score_q     <= '0;
            missPulse_q <= 1'b0;
            colPrev_q   <= '0;
            hitCnt_q    <= '0;
            missCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dirLeft_q   <= dirLeft_d;
            dirDown_q   <= dirDown_d;
            speed_q     <= speed_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            missPulse_q <= missPulse_d;
            colPrev_q   <= colPrev_d;
            hitCnt_q    <= hitCnt_d;
            missCnt_q   <= missCnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.Serve) state_d = PLAY;
            PLAY: if (netEdge) state_d = MISS;
            MISS: if (bus.FrameTick && missCnt_q == MissLast)
                      state_d = (lives_q == 2'd0) ? OVER : IDLE;
            OVER: if (bus.Serve) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: direction takes effect in the same cycle's step.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        dirLeft_d   = dirLeft_q;
        dirDown_d   = dirDown_q;
        speed_d     = speed_q;
        lives_d     = lives_q;
        score_d     = score_q;
        missPulse_d = 1'b0;
        colPrev_d   = bus.ColOut;
        hitCnt_d    = hitCnt_q;
        missCnt_d   = missCnt_q;
        unique case (state_q)
            IDLE: begin
                x_d = ServeXC;
                y_d = ServeYC;
                if (bus.Serve) begin
                    dirLeft_d = 1'b1;
                    dirDown_d = 1'b1;
                end
            end
            PLAY: begin
                unique case (bus.ColOut)
                    ColPaddle:  dirLeft_d = 1'b1;
                    ColWall:    dirLeft_d = 1'b0;
                    ColCeiling: dirDown_d = 1'b1;
                    ColFloor:   dirDown_d = 1'b0;
                    default:    ;
                endcase
                if (netEdge) begin
                    lives_d     = lives_q - 2'd1;
                    missPulse_d = 1'b1;
                    missCnt_d   = '0;
                end else begin
                    if (paddleHit) begin
                        score_d = (score_q == ScoreMax) ? ScoreMax : score_q + 10'd1;
                        if (hitCnt_q == HitLast) begin
                            hitCnt_d = '0;
                            speed_d  = (speed_q >= SpeedMaxC) ? SpeedMaxC : speed_q + SpeedOne;
                        end else begin
                            hitCnt_d = hitCnt_q + HitOne;
                        end
                    end
                    if (bus.FrameTick) begin
                        x_d = stepAxis(x_q, dirLeft_d, speed_q, XMaxC);
                        y_d = stepAxis(y_q, !dirDown_d, speed_q, YMaxC);
                    end
                end
            end
            MISS: begin
                if (bus.FrameTick) begin
                    if (missCnt_q == MissLast) begin
                        missCnt_d = '0;
                        if (lives_q != 2'd0) begin
                            x_d      = ServeXC;
                            y_d      = ServeYC;
                            speed_d  = SpeedInitC;
                            hitCnt_d = '0;
                        end
                    end else begin
                        missCnt_d = missCnt_q + MissOne;
                    end
                end
            end
            OVER: begin
                if (bus.Serve) begin
                    lives_d  = LivesInitC;
                    score_d  = '0;
                    speed_d  = SpeedInitC;
                    hitCnt_d = '0;
                    x_d      = ServeXC;
                    y_d      = ServeYC;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.XCord     = x_q;
        bus.YCord     = y_q;
        bus.Score     = score_q;
        bus.Lives     = lives_q;
        bus.State     = state_q;
        bus.MissPulse = missPulse_q;
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve, deflection, paddle speed-up, misses,
// game over, position clamping and asynchronous reset.
module tb_ball_motion;

    logic Clk;
    logic Rst_n;
    int   passCount;
    int   checkCount;

    ball_motion_if bus();

    ball_motion dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic applyStimulus(input logic ft, input logic sv, input logic [2:0] col);
        @(negedge Clk);
        bus.FrameTick = ft;
        bus.Serve     = sv;
        bus.ColOut    = col;
        @(posedge Clk);
        #1;
    endtask

    task automatic frameTicks(input int n, input logic [2:0] col);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, col);
            applyStimulus(1'b0, 1'b0, col);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        passCount     = 0;
        checkCount    = 0;
        Rst_n         = 1'b0;
        bus.FrameTick = 1'b0;
        bus.Serve     = 1'b0;
        bus.ColOut    = 3'b000;
        #23;
        checkOutput("rst_x", 32'(bus.XCord), 320);
        checkOutput("rst_y", 32'(bus.YCord), 232);
        checkOutput("rst_score", 32'(bus.Score), 0);
        checkOutput("rst_lives", 32'(bus.Lives), 3);
        checkOutput("rst_state", 32'(bus.State), 0);
        checkOutput("rst_pulse", 32'(bus.MissPulse), 0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Serve coincident with a frame tick takes no step
        applyStimulus(1'b1, 1'b1, 3'b000);
        checkOutput("serve_state", 32'(bus.State), 1);
        checkOutput("serve_x", 32'(bus.XCord), 320);
        checkOutput("serve_y", 32'(bus.YCord), 232);
        frameTicks(3, 3'b000);
        checkOutput("play3_x", 32'(bus.XCord), 314);
        checkOutput("play3_y", 32'(bus.YCord), 238);

        // Floor flips the ball upward and holding the code keeps it up
        applyStimulus(1'b0, 1'b0, 3'b110);
        frameTicks(1, 3'b110);
        checkOutput("floor_y", 32'(bus.YCord), 236);
        frameTicks(4, 3'b110);
        checkOutput("floor_hold_y", 32'(bus.YCord), 228);
        checkOutput("floor_hold_x", 32'(bus.XCord), 304);

        // Four paddle edges with walls between
        applyStimulus(1'b0, 1'b0, 3'b001);
        checkOutput("hit1_score", 32'(bus.Score), 1);
        applyStimulus(1'b0, 1'b0, 3'b100);
        applyStimulus(1'b0, 1'b0, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'b100);
        applyStimulus(1'b0, 1'b0, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'b100);
        applyStimulus(1'b0, 1'b0, 3'b001);
        applyStimulus(1'b0, 1'b0, 3'b100);
        checkOutput("hit4_score", 32'(bus.Score), 4);
        frameTicks(1, 3'b000);
        checkOutput("speed3_x", 32'(bus.XCord), 307);
        checkOutput("speed3_y", 32'(bus.YCord), 225);

        // Net edge on a frame tick: miss, no step
        applyStimulus(1'b1, 1'b0, 3'b011);
        checkOutput("miss_pulse", 32'(bus.MissPulse), 1);
        checkOutput("miss_lives", 32'(bus.Lives), 2);
        checkOutput("miss_state", 32'(bus.State), 2);
        checkOutput("miss_x", 32'(bus.XCord), 307);
        checkOutput("miss_y", 32'(bus.YCord), 225);
        applyStimulus(1'b0, 1'b0, 3'b011);
        checkOutput("miss_pulse_end", 32'(bus.MissPulse), 0);
        frameTicks(59, 3'b011);
        checkOutput("miss59_state", 32'(bus.State), 2);
        frameTicks(1, 3'b011);
        checkOutput("miss60_state", 32'(bus.State), 0);
        checkOutput("reserve_x", 32'(bus.XCord), 320);
        checkOutput("reserve_y", 32'(bus.YCord), 232);

        // Stale net code after re-serve does not cause a miss; speed back to 2
        applyStimulus(1'b0, 1'b1, 3'b011);
        frameTicks(1, 3'b011);
        checkOutput("stale_net_state", 32'(bus.State), 1);
        checkOutput("stale_net_x", 32'(bus.XCord), 318);
        checkOutput("stale_net_y", 32'(bus.YCord), 234);

        // Remaining lives run out
        applyStimulus(1'b0, 1'b0, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b011);
        checkOutput("miss2_lives", 32'(bus.Lives), 1);
        frameTicks(60, 3'b011);
        checkOutput("miss2_state", 32'(bus.State), 0);
        applyStimulus(1'b0, 1'b1, 3'b000);
        applyStimulus(1'b0, 1'b0, 3'b011);
        checkOutput("miss3_lives", 32'(bus.Lives), 0);
        frameTicks(60, 3'b011);
        checkOutput("over_state", 32'(bus.State), 3);
        checkOutput("over_score", 32'(bus.Score), 4);
        applyStimulus(1'b0, 1'b1, 3'b000);
        checkOutput("restart_state", 32'(bus.State), 0);
        checkOutput("restart_lives", 32'(bus.Lives), 3);
        checkOutput("restart_score", 32'(bus.Score), 0);

        // Drive the ball into both clamp limits
        applyStimulus(1'b0, 1'b1, 3'b000);
        frameTicks(159, 3'b000);
        checkOutput("clamp_pre_x", 32'(bus.XCord), 2);
        checkOutput("clamp_y", 32'(bus.YCord), 399);
        frameTicks(1, 3'b000);
        checkOutput("clamp_x0", 32'(bus.XCord), 0);
        frameTicks(1, 3'b000);
        checkOutput("clamp_x_hold", 32'(bus.XCord), 0);
        checkOutput("clamp_y_hold", 32'(bus.YCord), 399);

        // Asynchronous reset while the miss pulse is high
        applyStimulus(1'b0, 1'b0, 3'b011);
        checkOutput("pre_rst_pulse", 32'(bus.MissPulse), 1);
        Rst_n = 1'b0;
        #1;
        checkOutput("async_x", 32'(bus.XCord), 320);
        checkOutput("async_y", 32'(bus.YCord), 232);
        checkOutput("async_state", 32'(bus.State), 0);
        checkOutput("async_lives", 32'(bus.Lives), 3);
        checkOutput("async_pulse", 32'(bus.MissPulse), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 3'b000);
        checkOutput("post_rst_state", 32'(bus.State), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
